axis_pl_burst_router: RTL and testbench
=======================================

Name: axis_pl_burst_router

Overview:
- Sequences the 256-bit PL-side word stream produced by the PS-to-PL width packer.
- Each burst starts with one header word naming a destination channel and a payload length; the router forwards exactly that many payload words to the selected channel, then waits for the next header.
- Malformed headers are dropped. Bursts addressed to nonexistent channels are discarded with an error pulse.
- Sits between the packer's output FIFO and the per-channel DAC waveform buffers.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of the payload word counter; maximum burst is 2^CNT_W-1 words.
- TIMEOUT_CYC, 1024, idle-cycle limit inside a burst (used only with the optional feature).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset.
- s_axis_tdata  in  256  packed word from the packer FIFO.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  router accepts the input word.
- m_axis_tdata  out  256  payload word, shared by all channels.
- m_axis_tvalid  out  NUM_CH  one-hot valid; bit n addresses channel n.
- m_axis_tready  in  NUM_CH  per-channel ready.
- busy  out  1  high while in DATA or DISCARD.
- burst_done  out  1  one-cycle pulse when a burst completes, including zero-length bursts.
- err  out  1  one-cycle pulse on any header or protocol error.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, on port rst.
- Reset values: state HDR; m_axis_tdata=0, m_axis_tvalid=0, s_axis_tready=0 while rst is high; busy=0, burst_done=0, err=0; counter=0; sel=0.
- Mid-burst reset: asserting rst aborts the burst immediately and discards the output register. No partial-burst signalling.
- Input transfer occurs on s_axis_tvalid & s_axis_tready.
- Header format:
  - [31:24] magic, must equal 8'hA5.
  - [23:8] payload word count N (low CNT_W bits used; upper bits must be 0, else error).
  - [7:0] channel id.
  - [255:32] ignored.
- State HDR:
  - s_axis_tready=1.
  - On a transfer, decode the header (registered; decision takes effect next cycle).
  - Bad magic or nonzero count high bits: err pulse, stay in HDR.
  - Channel id >= NUM_CH with N>0: err pulse, load counter=N, go to DISCARD.
  - Channel id >= NUM_CH with N=0: err pulse only.
  - Valid channel with N=0: burst_done pulse, stay in HDR.
  - Valid channel with N>0: sel=id, counter=N, go to DATA.
- State DATA:
  - Single output register stage.
  - s_axis_tready = !out_valid | m_axis_tready[sel].
  - On an input transfer: load m_axis_tdata, set out_valid, decrement counter.
  - m_axis_tvalid = out_valid one-hot at bit sel; all other bits stay 0.
  - Latency: input transfer to m_axis_tvalid is 1 cycle. With the downstream always ready, throughput is 1 word/cycle.
  - Output holds data and valid stable until m_axis_tready[sel].
  - Simultaneous output accept and new input transfer: register reloads, no bubble.
  - Exit: when the last word (counter=1) is accepted at input, go to HDR the next cycle.
  - In HDR, s_axis_tready stays 0 until the final output word is accepted, so a header cannot overtake payload.
  - burst_done pulses on the cycle the final payload word is accepted downstream.
- State DISCARD:
  - s_axis_tready=1; each input transfer decrements the counter.
  - At counter=1 with a transfer: go to HDR. No output activity.
- busy = (state != HDR) | out_valid.
- No counter wrap: the counter is only loaded with N>=1 and only decremented to 0 at exit.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive DATA/DISCARD cycles with s_axis_tvalid=0.
  - Reaching TIMEOUT_CYC: err pulse, counter cleared, state forced to HDR.
  - A pending out_valid word is still delivered; no burst_done pulse.
  - The watchdog clears on any input transfer.
- Not defined: no watchdog logic; the router waits indefinitely mid-burst.

Test Plan:
- Header ch=2 N=3, then words D0..D2, all ready=1 -> m_axis_tvalid=4'b0100 for 3 consecutive cycles carrying D0,D1,D2 one cycle after each input; burst_done pulses with D2 accept; busy returns 0.
- Header ch=1 N=4, with m_axis_tready[1] toggling 1,0,0,1,... -> no word lost or duplicated; tdata stable while stalled; s_axis_tready low only when out_valid & !ready.
- Header magic 8'h5A -> err pulse, no state change; following valid header ch=0 N=1 routes normally.
- Header ch=7 (NUM_CH=4) N=2, then 2 words -> err pulse, zero m_axis_tvalid activity, next header accepted after 2 words.
- Header ch=3 N=0 -> burst_done pulse next cycle, stays in HDR. Header ch=0 N=5, assert rst after 2 words -> all outputs 0, next header processed cleanly.
- With ROUTER_TIMEOUT_EN, TIMEOUT_CYC=16: header ch=0 N=4, 1 word, then tvalid=0 for 16 cycles -> err pulse, busy=0, no burst_done.

Source files
------------

// File: rtl/axis_pl_burst_router.sv
// axis_pl_burst_router
//   Routes the 256-bit packed word stream from the PS-to-PL packer FIFO to
//   one of NUM_CH DAC waveform buffers. Each burst begins with a header word:
//     [31:24] magic 8'hA5, [23:8] payload count N, [7:0] channel id.
//   The next N words go to the selected channel. Bursts aimed at a channel
//   that does not exist are swallowed. Headers that are not recognised are
//   dropped with an err pulse.
//
//   Optional feature, enabled by defining ROUTER_TIMEOUT_EN: a watchdog
//   abandons a burst after TIMEOUT_CYC consecutive idle input cycles.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   s_axis_*       input stream (tdata 256, tvalid, tready)
//   m_axis_tdata   payload word, shared by all channels
//   m_axis_tvalid  one-hot valid per channel (NUM_CH)
//   m_axis_tready  per-channel ready (NUM_CH)
//   busy           burst in progress or output word pending
//   burst_done     one-cycle pulse on burst completion (zero-length included)
//   err            one-cycle pulse on header or protocol error
//
// State | meaning
// HDR     | waiting for a header word
// DATA    | forwarding payload words to channel sel
// DISCARD | swallowing payload of a burst to a nonexistent channel
module axis_pl_burst_router #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [255:0]      s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [255:0]      m_axis_tdata,
    output logic [NUM_CH-1:0] m_axis_tvalid,
    input  logic [NUM_CH-1:0] m_axis_tready,
    output logic              busy,
    output logic              burst_done,
    output logic              err
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [8:0] NUM_CH_L = 9'(NUM_CH);

    typedef enum logic [1:0] {ST_HDR, ST_DATA, ST_DISCARD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              out_last;
    logic              done_zl;
    logic              in_xfer;
    logic              out_acc;
    logic              wd_fire;

    logic              hdr_magic_ok;
    logic              hdr_hi_bad;
    logic              hdr_ch_ok;
    logic [CNT_W-1:0]  hdr_n;
    logic              hdr_good;

    assign in_xfer      = s_axis_tvalid & s_axis_tready;
    assign out_acc      = out_valid & m_axis_tready[sel];
    assign hdr_magic_ok = (s_axis_tdata[31:24] == 8'hA5);
    assign hdr_ch_ok    = ({1'b0, s_axis_tdata[7:0]} < NUM_CH_L);

    // Count bits above CNT_W must be zero; a wider counter zero-extends.
    if (CNT_W < 16) begin : g_cnt_narrow
        assign hdr_hi_bad = |s_axis_tdata[23:8+CNT_W];
        assign hdr_n      = s_axis_tdata[8 +: CNT_W];
    end else if (CNT_W == 16) begin : g_cnt_exact
        assign hdr_hi_bad = 1'b0;
        assign hdr_n      = s_axis_tdata[23:8];
    end else begin : g_cnt_wide
        assign hdr_hi_bad = 1'b0;
        assign hdr_n      = {{(CNT_W-16){1'b0}}, s_axis_tdata[23:8]};
    end

    assign hdr_good = hdr_magic_ok & ~hdr_hi_bad;

`ifdef ROUTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = (state != ST_HDR) & ~s_axis_tvalid
                   & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == ST_HDR || s_axis_tvalid || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_HDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR:
                if (in_xfer && hdr_good && hdr_n != '0)
                    state_nxt = hdr_ch_ok ? ST_DATA : ST_DISCARD;
            ST_DATA, ST_DISCARD:
                if ((in_xfer && cnt == CNT_W'(1)) || wd_fire)
                    state_nxt = ST_HDR;
            default:
                state_nxt = ST_HDR;
        endcase
    end

    // In HDR the input is held off while the last payload word is still in
    // the output register, so a new header never overtakes its payload.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_HDR:     s_axis_tready = ~out_valid;
            ST_DATA:    s_axis_tready = ~out_valid | m_axis_tready[sel];
            ST_DISCARD: s_axis_tready = 1'b1;
            default:    s_axis_tready = 1'b0;
        endcase
        if (rst) s_axis_tready = 1'b0;
        m_axis_tvalid = out_valid ? (NUM_CH'(1) << sel) : '0;
        busy          = (state != ST_HDR) | out_valid;
        burst_done    = done_zl | (out_acc & out_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            sel          <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            m_axis_tdata <= '0;
            done_zl      <= 1'b0;
            err          <= 1'b0;
        end else begin
            err     <= 1'b0;
            done_zl <= 1'b0;

            if (state == ST_HDR && in_xfer) begin
                if (!hdr_good) begin
                    err <= 1'b1;
                end else if (!hdr_ch_ok) begin
                    err <= 1'b1;
                    cnt <= hdr_n;
                end else if (hdr_n == '0) begin
                    done_zl <= 1'b1;
                end else begin
                    sel <= s_axis_tdata[SEL_W-1:0];
                    cnt <= hdr_n;
                end
            end

            // A load in the same cycle as a downstream accept simply refills
            // the register, giving one word per cycle with no bubble.
            if (state == ST_DATA && in_xfer) begin
                m_axis_tdata <= s_axis_tdata;
                out_valid    <= 1'b1;
                out_last     <= (cnt == CNT_W'(1));
                cnt          <= cnt - CNT_W'(1);
            end else if (out_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (state == ST_DISCARD && in_xfer)
                cnt <= cnt - CNT_W'(1);

            // Abandoned burst: a pending word still drains, but it no longer
            // counts as the end of a burst.
            if (wd_fire) begin
                err      <= 1'b1;
                cnt      <= '0;
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_pl_burst_router.sv
module tb_axis_pl_burst_router;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [255:0]   s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [255:0]   m_tdata;
    logic [NCH-1:0] m_tvalid;
    logic [NCH-1:0] m_tready = '0;
    logic           busy, burst_done, err;

    int n_checks = 0;
    int n_errors = 0;

    axis_pl_burst_router #(.NUM_CH(NCH), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy), .burst_done(burst_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Header with random filler in the ignored upper bits.
    function automatic logic [255:0] mk_hdr(input logic [7:0] magic, input logic [15:0] n,
                                             input logic [7:0] ch);
        logic [255:0] w;
        w = rnd256();
        w[31:0] = {magic, n, ch};
        return w;
    endfunction

    // Apply inputs half a cycle before the active edge, then let comb settle.
    task automatic drv(input logic v, input logic [255:0] d, input logic [NCH-1:0] r);
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
    endtask

    typedef struct {
        int           ch;
        logic [255:0] data;
        logic         last;
    } exp_t;

    logic [255:0] stream[$];
    exp_t         exp_q[$];
    int           exp_err, exp_zl;

    // Reference: walk the word list applying the header rules.
    task automatic model_parse();
        int i;
        logic [255:0] h;
        int n, ch;
        i = 0;
        exp_err = 0;
        exp_zl = 0;
        exp_q.delete();
        while (i < stream.size()) begin
            h  = stream[i];
            i++;
            n  = int'(h[23:8]);
            ch = int'(h[7:0]);
            if (h[31:24] != 8'hA5) begin
                exp_err++;
            end else if (ch >= NCH) begin
                exp_err++;
                i += n;
            end else if (n == 0) begin
                exp_zl++;
            end else begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back('{ch, stream[i], (k == n - 1)});
                    i++;
                end
            end
        end
    endtask

    task automatic gen_stream(input int bursts);
        int kind, n, ch;
        logic [7:0] mg;
        stream.delete();
        for (int b = 0; b < bursts; b++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                mg = 8'($urandom);
                if (mg == 8'hA5) mg = 8'h5A;
                stream.push_back(mk_hdr(mg, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 3))));
            end else begin
                n  = $urandom_range(0, 6);
                ch = (kind == 1) ? $urandom_range(NCH, 255) : $urandom_range(0, NCH - 1);
                stream.push_back(mk_hdr(8'hA5, 16'(n), 8'(ch)));
                for (int k = 0; k < n; k++) stream.push_back(rnd256());
            end
        end
    endtask

    task automatic run_random(input int bursts);
        int idx, tail, err_seen, zl_seen, ch;
        logic v, hold;
        logic [255:0] prev_d;
        logic [NCH-1:0] prev_v, r;
        exp_t e;
        gen_stream(bursts);
        model_parse();
        idx = 0; tail = 0; err_seen = 0; zl_seen = 0; hold = 1'b0;
        prev_d = '0; prev_v = '0;
        for (int cyc = 0; cyc < 20000 && tail < 4; cyc++) begin
            v = (idx < stream.size()) && ($urandom_range(0, 9) < 7);
            r = NCH'($urandom);
            drv(v, v ? stream[idx] : rnd256(), r);
            if ($countones(m_tvalid) > 1) check("onehot", 264'(m_tvalid), 264'(0));
            if (hold) check("stall_hold", {m_tvalid, m_tdata}, {prev_v, prev_d});
            if (|m_tvalid && !(|(m_tvalid & m_tready)))
                check("stall_tready", 264'(s_tready), 264'(0));
            if (|(m_tvalid & m_tready)) begin
                ch = 0;
                for (int c = 0; c < NCH; c++) if (m_tvalid[c]) ch = c;
                if (exp_q.size() == 0) begin
                    check("extra_word", 264'(1), 264'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_ch", 264'(ch), 264'(e.ch));
                    check("out_data", 264'(m_tdata), 264'(e.data));
                    check("done_last", 264'(burst_done), 264'(e.last));
                end
            end else if (burst_done) begin
                zl_seen++;
            end
            if (err) err_seen++;
            if (v && s_tready) idx++;
            hold   = |m_tvalid && !(|(m_tvalid & m_tready));
            prev_v = m_tvalid;
            prev_d = m_tdata;
            if (idx >= stream.size() && !busy) tail++;
        end
        check("stream_consumed", 264'(idx), 264'(stream.size()));
        check("words_left", 264'(exp_q.size()), 264'(0));
        check("err_count", 264'(err_seen), 264'(exp_err));
        check("zl_done_count", 264'(zl_seen), 264'(exp_zl));
        check("idle_busy", 264'(busy), 264'(0));
    endtask

    initial begin : main
        logic [255:0] d0, d1, d2, w;
        int e_cnt, d_cnt, seen;

        repeat (2) @(negedge clk);
        #1;
        check("rst_tready", 264'(s_tready), 264'(0));
        check("rst_tvalid", 264'(m_tvalid), 264'(0));
        check("rst_tdata", 264'(m_tdata), 264'(0));
        check("rst_flags", 264'({busy, burst_done, err}), 264'(0));
        @(negedge clk) rst = 1'b0;

        // ch=2 N=3, all ready
        d0 = rnd256(); d1 = rnd256(); d2 = rnd256();
        drv(1, mk_hdr(8'hA5, 16'd3, 8'd2), '1);
        check("hdr_tready", 264'(s_tready), 264'(1));
        drv(1, d0, '1);
        check("lat_tvalid0", 264'(m_tvalid), 264'(0));
        check("busy_data", 264'(busy), 264'(1));
        drv(1, d1, '1);
        check("d0", {m_tvalid, m_tdata}, {4'b0100, d0});
        drv(1, d2, '1);
        check("d1", {m_tvalid, m_tdata}, {4'b0100, d1});
        check("done_early", 264'(burst_done), 264'(0));
        drv(0, '0, '1);
        check("d2", {m_tvalid, m_tdata}, {4'b0100, d2});
        check("done_d2", 264'(burst_done), 264'(1));
        drv(0, '0, '1);
        check("after_burst", 264'({m_tvalid, busy, burst_done}), 264'(0));

        // bad magic, then ch=0 N=1
        drv(1, mk_hdr(8'h5A, 16'd1, 8'd0), '1);
        drv(0, '0, '1);
        check("magic_err", 264'({err, busy}), 264'(2'b10));
        w = rnd256();
        drv(1, mk_hdr(8'hA5, 16'd1, 8'd0), '1);
        check("err_pulse", 264'(err), 264'(0));
        drv(1, w, '1);
        drv(0, '0, '1);
        check("ch0_word", {m_tvalid, m_tdata}, {4'b0001, w});
        check("ch0_done", 264'(burst_done), 264'(1));
        drv(0, '0, '1);

        // ch=7 N=2 discarded, then ch=3 N=0
        drv(1, mk_hdr(8'hA5, 16'd2, 8'd7), '1);
        drv(1, rnd256(), '1);
        check("badch_err", 264'({err, busy}), 264'(2'b11));
        drv(1, rnd256(), '1);
        check("discard_quiet", 264'(m_tvalid), 264'(0));
        drv(1, mk_hdr(8'hA5, 16'd0, 8'd3), '1);
        check("discard_exit", 264'({m_tvalid, s_tready, busy}), 264'(6'b000010));
        drv(0, '0, '1);
        check("zl_done", 264'({burst_done, busy}), 264'(2'b10));
        drv(0, '0, '1);
        check("zl_done_pulse", 264'(burst_done), 264'(0));

        // mid-burst reset
        drv(1, mk_hdr(8'hA5, 16'd5, 8'd0), '0);
        drv(1, rnd256(), '0);
        drv(1, rnd256(), '0);
        drv(0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst", {m_tvalid, m_tdata}, 264'(0));
        check("mid_rst_ctl", 264'({s_tready, busy, burst_done, err}), 264'(0));
        @(negedge clk) rst = 1'b0;
        w = rnd256();
        drv(1, mk_hdr(8'hA5, 16'd1, 8'd1), '1);
        drv(1, w, '1);
        drv(0, '0, '1);
        check("post_rst_word", {m_tvalid, m_tdata}, {4'b0010, w});
        check("post_rst_done", 264'(burst_done), 264'(1));
        drv(0, '0, '1);

`ifdef ROUTER_TIMEOUT_EN
        w = rnd256();
        e_cnt = 0; d_cnt = 0; seen = 0;
        drv(1, mk_hdr(8'hA5, 16'd4, 8'd0), '1);
        drv(1, w, '1);
        for (int i = 0; i < 20; i++) begin
            drv(0, '0, '1);
            if (err) e_cnt++;
            if (burst_done) d_cnt++;
            if (m_tvalid == 4'b0001 && m_tdata == w) seen++;
        end
        check("to_err", 264'(e_cnt), 264'(1));
        check("to_no_done", 264'(d_cnt), 264'(0));
        check("to_word_out", 264'(seen), 264'(1));
        check("to_busy", 264'(busy), 264'(0));
`endif

        run_random(60);
        run_random(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
